// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the key-schedule blocks.
package aes_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SUB_WORD = 2'd1,
        S_RECOVER  = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    localparam logic [7:0] RCON_LAST = 8'h36;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] n);
        return n[7] ? ((n << 1) ^ 8'h1b) : (n << 1);
    endfunction

    // Walks the round constant backwards: 36, 1b, 80, 40, ... 01
    function automatic logic [7:0] inv_xtime(input logic [7:0] n);
        return n[0] ? ((n >> 1) ^ 8'h8d) : (n >> 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
                gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
                gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
                gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
    endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel AES S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // S-box as GF inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign word_o[8*gi +: 8] = sbox(word_i[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: round-10 key in, round keys 10..0 out.
// Define INV_KEY_EXP_EQKEY_EN to add equivalent-inverse-cipher round keys.
module inv_key_expansion
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] key_i,
    output logic         valid_o,
    output logic [127:0] round_key_o [0:NR]
`ifdef INV_KEY_EXP_EQKEY_EN
    ,
    output logic [127:0] eq_round_key_o [0:NR]
`endif
);

    state_e       state_reg;
    logic [127:0] key_reg [0:NR];
    logic [31:0]  temp_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   idx_reg;
    logic         ready_reg;
    logic         valid_reg;

    logic [127:0] next_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  rot_p3;
    logic [31:0]  sub_out;

    // The key being undone is always the one just above idx
    assign next_key = key_reg[idx_reg + 4'd1];
    assign {w0, w1, w2, w3} = next_key;
    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = rot_word(p3);

    sub_word u_sub_word (
        .word_i (rot_p3),
        .word_o (sub_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            for (int i = 0; i <= NR; i++) key_reg[i] <= '0;
            temp_reg  <= '0;
            rcon_reg  <= RCON_LAST;
            idx_reg   <= 4'(NR - 1);
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (valid_i) begin
                        key_reg[NR] <= key_i;
                        idx_reg     <= 4'(NR - 1);
                        rcon_reg    <= RCON_LAST;
                        state_reg   <= S_SUB_WORD;
                        ready_reg   <= 1'b0;
                    end
                end
                S_SUB_WORD: begin
                    temp_reg  <= sub_out;
                    state_reg <= S_RECOVER;
                end
                S_RECOVER: begin
                    key_reg[idx_reg] <= {w0 ^ temp_reg ^ {rcon_reg, 24'd0}, p1, p2, p3};
                    rcon_reg         <= inv_xtime(rcon_reg);
                    if (idx_reg == 4'd0) begin
                        state_reg <= S_DONE;
                        valid_reg <= 1'b1;
                    end else begin
                        idx_reg   <= idx_reg - 4'd1;
                        state_reg <= S_SUB_WORD;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = ready_reg;
    assign valid_o = valid_reg;

    generate
        for (genvar gi = 0; gi <= NR; gi++) begin : g_out
            assign round_key_o[gi] = key_reg[gi];
`ifdef INV_KEY_EXP_EQKEY_EN
            if (gi == 0 || gi == NR) begin : g_pass
                assign eq_round_key_o[gi] = key_reg[gi];
            end else begin : g_imc
                for (genvar gc = 0; gc < 4; gc++) begin : g_col
                    assign eq_round_key_o[gi][32*gc +: 32] = inv_mix_column(key_reg[gi][32*gc +: 32]);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed self-checking bench for inv_key_expansion using FIPS-197 key schedules.
module tb_inv_key_expansion;
    import aes_pkg::*;

    localparam int NR = 10;

    localparam logic [127:0] KEY_A10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_A0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_A1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_A9  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] KEY_B10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_B9  = 128'hac7766f319fadc2128d12941575c006e;

    logic         clk;
    logic         rst;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] key_i;
    logic         valid_o;
    logic [127:0] round_key_o [0:NR];
`ifdef INV_KEY_EXP_EQKEY_EN
    logic [127:0] eq_round_key_o [0:NR];
`endif

    int checks   = 0;
    int failures = 0;

    inv_key_expansion #(.NR(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .key_i       (key_i),
        .valid_o     (valid_o),
        .round_key_o (round_key_o)
`ifdef INV_KEY_EXP_EQKEY_EN
        ,
        .eq_round_key_o (eq_round_key_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

`ifdef INV_KEY_EXP_EQKEY_EN
    function automatic logic [7:0] tb_xt(input logic [7:0] n);
        return n[7] ? ((n << 1) ^ 8'h1b) : (n << 1);
    endfunction

    // Forward MixColumns undoes InvMixColumns, giving an independent cross-check
    function automatic logic [31:0] tb_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3,
                tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3)};
    endfunction
`endif

    // Accept one key, measure latency and check selected round keys
    task automatic run_key(input string tag, input logic [127:0] key,
                           input logic [127:0] exp0, input logic [127:0] exp1,
                           input logic [127:0] exp9);
        int cnt;
        int ready_hi;
        @(negedge clk);
        check({tag, "_ready_pre"}, 128'(ready_o), 128'd1);
        valid_i = 1'b1;
        key_i   = key;
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        cnt      = 1;
        ready_hi = 0;
        while (!valid_o && cnt < 40) begin
            if (ready_o) ready_hi++;
            @(posedge clk);
            #1;
            cnt++;
        end
        check({tag, "_latency"}, 128'(cnt), 128'd21);
        check({tag, "_ready_busy"}, 128'(ready_hi), 128'd0);
        check({tag, "_rk0"}, round_key_o[0], exp0);
        check({tag, "_rk1"}, round_key_o[1], exp1);
        check({tag, "_rk9"}, round_key_o[9], exp9);
        check({tag, "_rk10"}, round_key_o[10], key);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, {127'd0, valid_o}, 128'd0);
        check({tag, "_ready_post"}, {127'd0, ready_o}, 128'd1);
    endtask

    initial begin
        int cnt;
        int pulses;
        rst     = 1'b1;
        valid_i = 1'b0;
        key_i   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {127'd0, ready_o}, 128'd1);
        check("reset_valid", {127'd0, valid_o}, 128'd0);
        check("reset_rk0", round_key_o[0], 128'd0);
        check("reset_rk10", round_key_o[10], 128'd0);
        rst = 1'b0;

        run_key("vecA", KEY_A10, KEY_A0, KEY_A1, KEY_A9);
        run_key("vecB", KEY_B10, KEY_B0, KEY_B1, KEY_B9);

        // valid_i held high across the end of a run; swap key while idle
        @(negedge clk);
        valid_i = 1'b1;
        key_i   = KEY_A10;
        @(posedge clk);
        #1;
        cnt = 1;
        while (!valid_o && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("hold_latency", 128'(cnt), 128'd21);
        @(posedge clk);
        #1;
        check("hold_idle_ready", {127'd0, ready_o}, 128'd1);
        key_i = KEY_B10;
        @(posedge clk);
        #1;
        check("hold_reaccept", {127'd0, ready_o}, 128'd0);
        valid_i = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 30; i++) begin
            if (valid_o) pulses++;
            @(posedge clk);
            #1;
        end
        check("hold_pulses", 128'(pulses), 128'd1);
        check("hold_rk0", round_key_o[0], KEY_B0);

        // Reset partway through a run
        @(negedge clk);
        valid_i = 1'b1;
        key_i   = KEY_A10;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", {127'd0, ready_o}, 128'd1);
        check("midrst_valid", {127'd0, valid_o}, 128'd0);
        check("midrst_rk10", round_key_o[10], 128'd0);
        check("midrst_rk0", round_key_o[0], 128'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        check("midrst_no_pulse", 128'(pulses), 128'd0);
        run_key("postrst", KEY_A10, KEY_A0, KEY_A1, KEY_A9);

`ifdef INV_KEY_EXP_EQKEY_EN
        check("imc_column", 128'(inv_mix_column(32'h8e4da1bc)), 128'h db135345);
        check("eq_rk0", eq_round_key_o[0], round_key_o[0]);
        check("eq_rk10", eq_round_key_o[10], round_key_o[10]);
        for (int i = 1; i < NR; i++) begin
            logic [127:0] remix;
            for (int c = 0; c < 4; c++) remix[32*c +: 32] = tb_mix(eq_round_key_o[i][32*c +: 32]);
            check($sformatf("eq_rk%0d", i), remix, round_key_o[i]);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
